// File: rtl/omok_move_controller.sv
// Omok board owner: accepts edge-detected put/undo, keeps history for undo, runs a 32-cycle five-in-a-row scan.
// Latency: put visible at E+2, scan result at E+34; undo visible at E+2; new game from WON at E+1.
// Backpressure: requests arriving while busy are dropped silently; refused requests pulse reject for one cycle.
module omok_move_controller #(
    parameter int MAP_N      = 10,
    parameter int HIST_DEPTH = 100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             cur_pos,
    input  logic                   put,
    input  logic                   undo,
    output logic [MAP_N*MAP_N-1:0] board_state,
    output logic [MAP_N*MAP_N-1:0] turn_map,
    output logic [7:0]             move_count,
    output logic                   busy,
    output logic                   game_over,
    output logic                   winner,
    output logic                   reject
);
    localparam int CELLS = MAP_N * MAP_N;
    localparam int IW    = $clog2(CELLS);
    localparam int HW    = $clog2(HIST_DEPTH);
    localparam logic signed [9:0] N_S = 10'(MAP_N);

    typedef enum logic [2:0] {IDLE, PLACE, UNDO, CHECK, WON} state_t;
    state_t state, state_n;

    logic          put_prev, undo_prev;
    logic [7:0]    hist [HIST_DEPTH];
    logic [IW-1:0] pos_q;
    logic [7:0]    row_q, col_q;
    logic          colour_q;
    logic [4:0]    cnt;
    logic [3:0]    dir_run;
    logic          alive_q, won_q;
    logic          rej;

    logic          put_edge, undo_edge, cur_ok, put_bad;
    logic [IW-1:0] cur_idx, top_idx;
    logic [HW-1:0] top_ptr;

    assign put_edge  = put & ~put_prev;
    assign undo_edge = undo & ~undo_prev;
    assign cur_ok    = cur_pos < 8'(CELLS);
    assign cur_idx   = cur_ok ? IW'(cur_pos) : '0;
    assign put_bad   = !cur_ok || board_state[cur_idx];
    assign top_ptr   = (move_count == 8'd0) ? '0 : HW'(move_count - 8'd1);
    assign top_idx   = IW'(hist[top_ptr]);

    assign busy      = (state == PLACE) || (state == UNDO) || (state == CHECK);
    assign game_over = (state == WON);

    // Probe address: cnt[4:3] = direction, cnt[2] = negative side, cnt[1:0]+1 = step.
    logic signed [9:0] stepv, s, off_r, off_c, pr, pc;
    logic              onboard, hit, alive_eff, win_next;
    logic [IW-1:0]     pidx;
    logic [3:0]        run_base, new_run;

    always_comb begin
        stepv = $signed({8'd0, cnt[1:0]}) + 10'sd1;
        s     = cnt[2] ? -stepv : stepv;
        off_r = 10'sd0;
        off_c = 10'sd0;
        case (cnt[4:3])
            2'd0:    off_c = s;
            2'd1:    off_r = s;
            2'd2:    begin off_r = s; off_c = s;  end
            default: begin off_r = s; off_c = -s; end
        endcase
        pr        = $signed({2'b00, row_q}) + off_r;
        pc        = $signed({2'b00, col_q}) + off_c;
        onboard   = (pr >= 10'sd0) && (pr < N_S) && (pc >= 10'sd0) && (pc < N_S);
        pidx      = onboard ? IW'(int'(pr) * MAP_N + int'(pc)) : '0;
        hit       = onboard && board_state[pidx] && (turn_map[pidx] == colour_q);
        alive_eff = (cnt[1:0] == 2'd0) ? 1'b1 : alive_q;
        run_base  = (cnt[2:0] == 3'd0) ? 4'd0 : dir_run;
        new_run   = run_base + {3'd0, alive_eff && hit};
        win_next  = won_q || ((cnt[2:0] == 3'd7) && (new_run >= 4'd4));
    end

    always_comb begin
        state_n = state;
        rej     = 1'b0;
        case (state)
            IDLE: begin
                if (put_edge) begin
                    if (put_bad) rej = 1'b1;
                    else         state_n = PLACE;
                end else if (undo_edge) begin
                    if (move_count == 8'd0) rej = 1'b1;
                    else                    state_n = UNDO;
                end
            end
            PLACE: state_n = CHECK;
            UNDO:  state_n = IDLE;
            CHECK: if (cnt == 5'd31) state_n = win_next ? WON : IDLE;
            WON: begin
                if (put_edge) state_n = IDLE;
                else if (undo_edge) begin
                    if (move_count == 8'd0) rej = 1'b1;
                    else                    state_n = UNDO;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            put_prev    <= 1'b1;
            undo_prev   <= 1'b1;
            board_state <= '0;
            turn_map    <= '0;
            move_count  <= 8'd0;
            winner      <= 1'b0;
            reject      <= 1'b0;
            pos_q       <= '0;
            row_q       <= 8'd0;
            col_q       <= 8'd0;
            colour_q    <= 1'b0;
            cnt         <= 5'd0;
            dir_run     <= 4'd0;
            alive_q     <= 1'b0;
            won_q       <= 1'b0;
            for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= 8'd0;
        end else begin
            put_prev  <= put;
            undo_prev <= undo;
            reject    <= rej;
            case (state)
                IDLE: if (state_n == PLACE) begin
                    pos_q    <= cur_idx;
                    row_q    <= cur_pos / 8'(MAP_N);
                    col_q    <= cur_pos % 8'(MAP_N);
                    colour_q <= move_count[0];
                end
                PLACE: begin
                    board_state[pos_q]     <= 1'b1;
                    turn_map[pos_q]        <= colour_q;
                    hist[HW'(move_count)]  <= 8'(pos_q);
                    move_count             <= move_count + 8'd1;
                    cnt                    <= 5'd0;
                    dir_run                <= 4'd0;
                    alive_q                <= 1'b1;
                    won_q                  <= 1'b0;
                end
                UNDO: begin
                    board_state[top_idx] <= 1'b0;
                    turn_map[top_idx]    <= 1'b0;
                    move_count           <= move_count - 8'd1;
                    winner               <= 1'b0;
                end
                CHECK: begin
                    cnt     <= cnt + 5'd1;
                    dir_run <= new_run;
                    alive_q <= alive_eff && hit;
                    won_q   <= win_next;
                    if (cnt == 5'd31) winner <= win_next ? colour_q : 1'b0;
                end
                WON: if (put_edge) begin
                    board_state <= '0;
                    turn_map    <= '0;
                    move_count  <= 8'd0;
                    winner      <= 1'b0;
                    for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= 8'd0;
                end
                default: ;
            endcase
        end
    end
endmodule
